// File: rtl/addsub_result_stage_if.sv
// Handshake bus between the add/subtract datapath, the result stage and its consumer.
interface addsub_result_stage_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic [WIDTH-1:0] in_s;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_s, in_cout, out_ready,
    output in_ready, out_valid, out_s, out_carry, out_zero, out_neg, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, in_s, in_cout, out_ready,
    input  in_ready, out_valid, out_s, out_carry, out_zero, out_neg, out_ovf
  );
endinterface

// File: rtl/addsub_result_stage.sv
// Registers add/subtract results with derived ALU flags in a 2-entry FIFO,
// plus a sticky overflow flag and a wrapping delivered-result counter.
module addsub_result_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  addsub_result_stage_if.slave  bus,
  input  logic                  clr_sticky,
  output logic                  ovf_sticky,
  output logic [CNT_W-1:0]      res_count
);
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t state_q, state_d;

  logic                  rdy_q;
  logic                  wr_ptr, rd_ptr;
  logic [1:0][WIDTH-1:0] s_mem;
  logic [1:0]            carry_mem, zero_mem, neg_mem, ovf_mem;

  logic             push, pop, valid;
  logic [WIDTH-1:0] b_eff;
  logic             ovf_in, zero_in, neg_in, carry_in;

  assign valid = (state_q != EMPTY);
  assign push  = bus.in_valid & rdy_q;
  assign pop   = valid & bus.out_ready;

  // Flags are derived from the operands as applied, never from a recomputed sum.
  assign b_eff    = bus.in_b ^ {WIDTH{bus.in_mode}};
  assign ovf_in   = (bus.in_a[MSB] == b_eff[MSB]) && (bus.in_s[MSB] != bus.in_a[MSB]);
  assign zero_in  = ~|bus.in_s;
  assign neg_in   = bus.in_s[MSB];
  assign carry_in = bus.in_cout ^ bus.in_mode;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (!push && pop) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Ready is a register of the next occupancy, so it never depends on in_valid.
      rdy_q   <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      s_mem     <= '0;
      carry_mem <= '0;
      zero_mem  <= '0;
      neg_mem   <= '0;
      ovf_mem   <= '0;
    end else begin
      if (push) begin
        s_mem[wr_ptr]     <= bus.in_s;
        carry_mem[wr_ptr] <= carry_in;
        zero_mem[wr_ptr]  <= zero_in;
        neg_mem[wr_ptr]   <= neg_in;
        ovf_mem[wr_ptr]   <= ovf_in;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      res_count  <= '0;
    end else begin
      if (push && ovf_in) ovf_sticky <= 1'b1;
      else if (clr_sticky) ovf_sticky <= 1'b0;
      if (pop) res_count <= res_count + CNT_W'(1);
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = valid;
  assign bus.out_s     = s_mem[rd_ptr];
  assign bus.out_carry = carry_mem[rd_ptr];
  assign bus.out_zero  = zero_mem[rd_ptr];
  assign bus.out_neg   = neg_mem[rd_ptr];
  assign bus.out_ovf   = ovf_mem[rd_ptr];
endmodule
